// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing the async_fifo write port among requesters
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 4,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                          wr_clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          full,
  output logic                          wr_en,
  output logic [DATA_WIDTH-1:0]         din,
  output logic                          grant_valid,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic [CNT_WIDTH-1:0]          beat_count
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = MAX_BURST > 1 ? $clog2(MAX_BURST) : 1;
  typedef enum logic {IDLE, BURST} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d, grant_id_q, grant_id_d, sel_id, next_id;
  logic [IW:0] idx;
  logic [BW-1:0] burst_cnt_q, burst_cnt_d;
  logic [CNT_WIDTH-1:0] beat_count_q, beat_count_d;
  logic fire, last, grant_hold;
  assign grant_valid = state_q == BURST;
  assign grant_id = grant_id_q;
  assign beat_count = beat_count_q;
  assign grant_hold = req_valid[grant_id_q];
  assign fire = grant_valid && grant_hold && !full;
  assign last = burst_cnt_q == BW'(MAX_BURST - 1);
  assign next_id = grant_id_q == IW'(NUM_REQ - 1) ? '0 : grant_id_q + 1'b1;
  // first valid requester at or after rr_ptr; scanning downward lets the nearest hit win
  always_comb begin
    sel_id = rr_ptr_q;
    idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = {1'b0, rr_ptr_q} + (IW+1)'(k);
      idx = idx >= (IW+1)'(NUM_REQ) ? idx - (IW+1)'(NUM_REQ) : idx;
      sel_id = req_valid[idx[IW-1:0]] ? idx[IW-1:0] : sel_id;
    end
  end
  // state register with asynchronous reset
  always_ff @(posedge wr_clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rr_ptr_q <= '0;
      grant_id_q <= '0;
      burst_cnt_q <= '0;
      beat_count_q <= '0;
    end else begin
      state_q <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      burst_cnt_q <= burst_cnt_d;
      beat_count_q <= beat_count_d;
    end
  end
  // next state: grant in IDLE, leave BURST on a full burst or when the owner drops valid
  always_comb begin
    state_d = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_id_d = grant_id_q;
    burst_cnt_d = fire ? burst_cnt_q + 1'b1 : burst_cnt_q;
    beat_count_d = fire ? beat_count_q + 1'b1 : beat_count_q;
    if (state_q == IDLE) begin
      if (|req_valid) begin
        grant_id_d = sel_id;
        burst_cnt_d = '0;
        state_d = BURST;
      end
    end else if (!grant_hold || (fire && last)) begin
      state_d = IDLE;
      rr_ptr_d = next_id;
    end
  end
  // outputs: only the granted requester sees ready, and only while the FIFO has room
  always_comb begin
    req_ready = '0;
    req_ready[grant_id_q] = grant_valid && !full;
    wr_en = fire;
    din = fire ? req_data[grant_id_q*DATA_WIDTH +: DATA_WIDTH] : '0;
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed tests checked against a cycle model of the arbiter rules
module tb_fifo_wr_arbiter;
  localparam int NR = 4;
  localparam int DW = 32;
  localparam int MB = 4;
  localparam int DEPTH = 8;
  logic wr_clk = 0, rd_clk = 0, rst = 1, full = 0;
  logic [NR-1:0] req_valid = '0, req_ready;
  logic [NR*DW-1:0] req_data = '0;
  logic wr_en, grant_valid;
  logic [DW-1:0] din;
  logic [1:0] grant_id;
  logic [31:0] beat_count;
  int errors = 0, checks = 0;
  logic [NR-1:0] en = '0;
  int seq[NR], lim[NR];
  logic [DW-1:0] base[NR];
  logic full_force = 0, e2e = 0;
  logic [31:0] dq[$], fq[$], rq[$];
  int gl[$], bl[$];
  bit m_busy = 0;
  int m_owner = 0, m_next = 0, m_beats = 0;
  logic [31:0] m_total = 0;
  logic [NR-1:0] er;
  logic ew;
  logic [DW-1:0] ed;
  bit found;
  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB), .CNT_WIDTH(32)) dut (
    .wr_clk(wr_clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .full(full), .wr_en(wr_en), .din(din), .grant_valid(grant_valid), .grant_id(grant_id),
    .beat_count(beat_count)
  );
  always #5 wr_clk = ~wr_clk;
  always #7 rd_clk = ~rd_clk;
  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask
  function automatic bit all_done();
    for (int i = 0; i < NR; i++) if (en[i] && seq[i] < lim[i]) return 0;
    return 1;
  endfunction
  task automatic wait_done(input int budget, input string nm);
    int n = 0;
    while (!all_done() && n < budget) begin
      @(posedge wr_clk);
      n++;
    end
    chk(nm, all_done(), 1);
  endtask
  task automatic do_reset();
    @(posedge wr_clk);
    rst = 1;
    en = '0;
    full_force = 0;
    e2e = 0;
    for (int i = 0; i < NR; i++) begin
      lim[i] = 0;
      base[i] = 32'(i) << 24;
    end
    repeat (3) @(posedge wr_clk);
    #3 rst = 0;
  endtask
  // stimulus: each requester streams base+seq until it reaches its beat limit
  always @(posedge wr_clk) begin
    #1;
    for (int i = 0; i < NR; i++) begin
      req_valid[i] = en[i] && (seq[i] < lim[i]);
      req_data[i*DW +: DW] = base[i] + 32'(seq[i]);
    end
    full = e2e ? (fq.size() >= DEPTH) : full_force;
  end
  // read side of the FIFO drains one word per read clock
  always @(posedge rd_clk) if (fq.size() > 0) rq.push_back(fq.pop_front());
  // compare DUT against the model every cycle, then advance the model
  always @(negedge wr_clk) begin
    if (rst) begin
      chk("rst_ready", req_ready, 0);
      chk("rst_wr_en", wr_en, 0);
      chk("rst_din", din, 0);
      chk("rst_gvalid", grant_valid, 0);
      chk("rst_gid", grant_id, 0);
      chk("rst_beats", beat_count, 0);
      m_busy = 0; m_owner = 0; m_next = 0; m_beats = 0; m_total = 0;
      gl.delete(); bl.delete(); dq.delete(); fq.delete(); rq.delete();
      for (int i = 0; i < NR; i++) seq[i] = 0;
    end else begin
      er = '0; ew = 0; ed = '0;
      if (m_busy) begin
        er[m_owner] = !full;
        ew = req_valid[m_owner] && !full;
        ed = ew ? req_data[m_owner*DW +: DW] : '0;
      end
      chk("req_ready", req_ready, er);
      chk("wr_en", wr_en, ew);
      chk("din", din, ed);
      chk("grant_valid", grant_valid, m_busy);
      chk("grant_id", grant_id, m_owner);
      chk("beat_count", beat_count, m_total);
      if (wr_en) begin
        dq.push_back(din);
        fq.push_back(din);
      end
      if (!m_busy) begin
        found = 0;
        for (int k = 0; k < NR; k++)
          if (!found && req_valid[(m_next + k) % NR]) begin
            found = 1;
            m_owner = (m_next + k) % NR;
          end
        if (found) begin
          m_busy = 1;
          m_beats = 0;
          gl.push_back(m_owner);
        end
      end else if (ew) begin
        m_total++;
        m_beats++;
        seq[m_owner]++;
        if (m_beats == MB) begin
          m_busy = 0;
          m_next = (m_owner + 1) % NR;
          bl.push_back(m_beats);
        end
      end else if (!req_valid[m_owner]) begin
        m_busy = 0;
        m_next = (m_owner + 1) % NR;
        bl.push_back(m_beats);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  initial begin
    int cnt[NR];
    int nxt[NR];
    int bad;
    int t1_len[3];
    int n;
    t1_len = '{4, 4, 2};
    for (int i = 0; i < NR; i++) seq[i] = 0;
    // single requester, ten beats split into 4/4/2
    do_reset();
    base[2] = 32'h1A2B_0000; en[2] = 1; lim[2] = 10;
    wait_done(60, "t1_done");
    repeat (3) @(posedge wr_clk);
    #2;
    chk("t1_bursts", bl.size(), 3);
    for (int k = 0; k < 3; k++) begin
      chk("t1_len", k < bl.size() ? bl[k] : -1, t1_len[k]);
      chk("t1_gid", k < gl.size() ? gl[k] : -1, 2);
    end
    chk("t1_beat_count", beat_count, 10);
    chk("t1_words", dq.size(), 10);
    for (int k = 0; k < 10; k++) chk("t1_data", k < dq.size() ? dq[k] : 32'hDEAD, 32'h1A2B_0000 + 32'(k));
    // all four requesters saturating: 8 bursts of 4 in 40 cycles
    do_reset();
    for (int i = 0; i < NR; i++) begin en[i] = 1; lim[i] = 100; end
    repeat (41) @(posedge wr_clk);
    #2;
    chk("t2_beat_count", beat_count, 32);
    chk("t2_grants", gl.size() >= 8, 1);
    for (int k = 0; k < 8; k++) begin
      chk("t2_order", k < gl.size() ? gl[k] : -1, k % NR);
      chk("t2_len", k < bl.size() ? bl[k] : -1, 4);
    end
    for (int i = 0; i < NR; i++) cnt[i] = 0;
    foreach (dq[k]) if (dq[k][31:24] < NR) cnt[dq[k][31:24]]++;
    for (int i = 0; i < NR; i++) chk("t2_per_req", cnt[i], 8);
    // full held for five cycles during beat 2
    do_reset();
    base[1] = 32'hC0DE_0000; en[1] = 1; lim[1] = 4;
    repeat (3) @(posedge wr_clk);
    full_force = 1;
    repeat (2) @(posedge wr_clk);
    #2;
    chk("t3_stall_wr_en", wr_en, 0);
    chk("t3_stall_ready", req_ready, 0);
    chk("t3_stall_gid", grant_id, 1);
    chk("t3_stall_gvalid", grant_valid, 1);
    chk("t3_stall_beats", beat_count, 1);
    repeat (3) @(posedge wr_clk);
    full_force = 0;
    wait_done(40, "t3_done");
    repeat (3) @(posedge wr_clk);
    #2;
    chk("t3_bursts", bl.size(), 1);
    chk("t3_len", bl.size() > 0 ? bl[0] : -1, 4);
    chk("t3_beat_count", beat_count, 4);
    chk("t3_words", dq.size(), 4);
    for (int k = 0; k < 4; k++) chk("t3_data", k < dq.size() ? dq[k] : 32'hDEAD, 32'hC0DE_0000 + 32'(k));
    // owner drops valid after one beat while requester 3 waits
    do_reset();
    base[0] = 32'hA000_0000; base[3] = 32'hD000_0000;
    en[0] = 1; en[3] = 1; lim[0] = 1; lim[3] = 2;
    wait_done(40, "t4_done");
    repeat (3) @(posedge wr_clk);
    #2;
    chk("t4_grants", gl.size(), 2);
    chk("t4_first", gl.size() > 0 ? gl[0] : -1, 0);
    chk("t4_second", gl.size() > 1 ? gl[1] : -1, 3);
    chk("t4_len0", bl.size() > 0 ? bl[0] : -1, 1);
    chk("t4_len1", bl.size() > 1 ? bl[1] : -1, 2);
    chk("t4_beat_count", beat_count, 3);
    chk("t4_w0", dq.size() > 0 ? dq[0] : 32'hDEAD, 32'hA000_0000);
    chk("t4_w1", dq.size() > 1 ? dq[1] : 32'hDEAD, 32'hD000_0000);
    chk("t4_w2", dq.size() > 2 ? dq[2] : 32'hDEAD, 32'hD000_0001);
    // reset asserted during beat 2, then arbitration restarts at requester 0
    do_reset();
    base[0] = 32'hB000_0000; en[0] = 1; lim[0] = 100;
    repeat (3) @(posedge wr_clk);
    #2;
    chk("t5_pre_wr_en", wr_en, 1);
    chk("t5_pre_beats", beat_count, 1);
    rst = 1;
    #1;
    chk("t5_rst_wr_en", wr_en, 0);
    chk("t5_rst_ready", req_ready, 0);
    chk("t5_rst_din", din, 0);
    chk("t5_rst_beats", beat_count, 0);
    chk("t5_rst_gvalid", grant_valid, 0);
    for (int i = 0; i < NR; i++) begin en[i] = 1; lim[i] = 2; base[i] = 32'(i) << 24; end
    repeat (2) @(posedge wr_clk);
    #3 rst = 0;
    wait_done(60, "t5_done");
    repeat (3) @(posedge wr_clk);
    #2;
    chk("t5_grants", gl.size(), 4);
    for (int k = 0; k < 4; k++) chk("t5_order", k < gl.size() ? gl[k] : -1, k);
    chk("t5_beat_count", beat_count, 8);
    // four requesters x 16 beats through a depth-8 FIFO drained on a slower clock
    do_reset();
    e2e = 1;
    for (int i = 0; i < NR; i++) begin en[i] = 1; lim[i] = 16; end
    wait_done(600, "t6_done");
    n = 0;
    while (rq.size() < 64 && n < 300) begin
      @(posedge wr_clk);
      n++;
    end
    #2;
    chk("t6_read_words", rq.size(), 64);
    chk("t6_beat_count", beat_count, 64);
    for (int i = 0; i < NR; i++) nxt[i] = 0;
    bad = 0;
    foreach (rq[k]) begin
      if (rq[k][31:24] >= NR || 32'(rq[k][23:0]) != 32'(nxt[rq[k][31:24]])) bad++;
      else nxt[rq[k][31:24]]++;
    end
    chk("t6_order_errors", bad, 0);
    for (int i = 0; i < NR; i++) chk("t6_per_req", nxt[i], 16);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin write-side arbiter that shares the single write port of async_fifo among NUM_REQ requesters in the write clock domain. Each requester presents a valid/ready stream. The arbiter grants one requester at a time for a burst of up to MAX_BURST beats and drives wr_en/din straight into the FIFO, honouring full. It sits between the write-domain producers and the async_fifo write port.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 32, data width; matches async_fifo DATA_WIDTH
MAX_BURST, 4, max beats per grant before forced rotation (1..256)
CNT_WIDTH, 32, width of the accepted-beat counter

Ports:
wr_clk  in  1  write-domain clock; all logic on posedge
rst  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  per-requester data valid
req_data  in  NUM_REQ*DATA_WIDTH  requester i data at bits [i*DATA_WIDTH +: DATA_WIDTH]
req_ready  out  NUM_REQ  per-requester accept; combinational
full  in  1  async_fifo full flag (write domain)
wr_en  out  1  async_fifo write enable; combinational
din  out  DATA_WIDTH  async_fifo write data; combinational
grant_valid  out  1  a burst is active (state BURST)
grant_id  out  $clog2(NUM_REQ)  index of the granted requester
beat_count  out  CNT_WIDTH  total beats written since reset; wraps

Behaviour:
- Reset (rst=1, asynchronous): state=IDLE, rr_ptr=0, grant_id=0, burst_cnt=0, beat_count=0. req_ready=0, wr_en=0, din=0, grant_valid=0 for as long as rst is high.
- States: IDLE and BURST.
- IDLE:
  - req_ready=0, wr_en=0, din=0.
  - If any req_valid is set, grant_id <= the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ. Then burst_cnt <= 0 and state <= BURST.
  - Otherwise stay in IDLE.
- BURST:
  - grant_valid=1.
  - req_ready[grant_id] = !full. All other req_ready bits are 0.
  - fire = req_valid[grant_id] && !full.
  - wr_en = fire. din = req_data of grant_id when fire, else 0.
  - On fire: beat_count++ (wraps modulo 2^CNT_WIDTH) and burst_cnt++.
- BURST exit conditions (checked every cycle):
  - (a) fire with burst_cnt==MAX_BURST-1: state <= IDLE, rr_ptr <= grant_id+1 (mod NUM_REQ).
  - (b) req_valid[grant_id]==0: state <= IDLE, rr_ptr <= grant_id+1. No beat is written that cycle.
  - (c) full==1 with valid still high: stall. Remain in BURST, burst_cnt unchanged, no write. Stalls last indefinitely.
- Latency: one IDLE arbitration cycle before each burst. Beats then flow at one per cycle while !full. This gives a minimum 1-cycle bubble between bursts.
- Fairness: a requester that holds valid continuously waits at most (NUM_REQ-1) × (MAX_BURST+1) non-stalled cycles for a grant.
- Simultaneous requests in IDLE: round-robin order starting at rr_ptr. rr_ptr moves only on burst exit.
- Valid/data stability: a requester may drop valid while granted, which ends its burst (rule b). Data is sampled only on fire.
- Full toggling mid-burst: each beat is written only in a cycle with !full. No beat is duplicated or lost.
- rr_ptr wrap: NUM_REQ-1 wraps to 0. Only legal 0..NUM_REQ-1 values are reachable, including when NUM_REQ is not a power of 2.

Test Plan:
- Single requester: req 2 streams 10 beats 0x1A2B_0000..0x1A2B_0009 continuously, full=0, MAX_BURST=4.
  - Required: three bursts of 4, 4, 2 beats, each preceded by one IDLE cycle.
  - FIFO content is in order. beat_count=10.
- All 4 requesters hold valid continuously, data = {id, seq}:
  - Required: grant order 0,1,2,3,0,... with exactly 4 beats per grant.
  - No requester starves. beat_count=32 after 40 cycles.
- full asserted for 5 cycles during beat 2 of a burst:
  - Required: wr_en=0 and req_ready=0 during the stall, grant_id unchanged.
  - Burst resumes and ends after 4 total beats with no duplicate or lost data.
- Granted requester drops valid after 1 beat while requester 3 is waiting:
  - Required: the burst ends with 1 beat and the next grant goes to requester 3.
- rst pulsed high mid-burst (beat 2):
  - Required: wr_en/req_ready drop to 0 immediately and beat_count=0.
  - After rst release, arbitration restarts at requester 0.
- End-to-end with async_fifo (wr_clk 10 ns, rd_clk 14 ns), 4 requesters × 16 beats:
  - Required: the read side receives all 64 words.
  - Per-requester order is preserved and nothing is written while full=1.
